// File: rtl/lsu_mem_bridge_pkg.sv
// Shared types and funct3 encodings for the load/store bridge.
package lsu_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_X
    } size_e;

    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            2'b10:   return SZ_W;
            default: return SZ_X;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extension
// and legality/alignment decode for one access.
module lsu_align
    import lsu_mem_bridge_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    size_e       size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        size = f3_size(func3);

        // Unsigned variants exist only for loads.
        case (func3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase

        be         = '0;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            SZ_W: begin
                be         = 4'b1111;
                misaligned = |addr;
            end
            default: ;
        endcase

        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        rdata_ext = rdata;
        case (size)
            SZ_B: rdata_ext = func3[2] ? {24'b0, byte_lane}
                                       : {{24{byte_lane[7]}}, byte_lane};
            SZ_H: rdata_ext = func3[2] ? {16'b0, half_lane}
                                       : {{16{half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding load/store bridge from the core's memory stage to a
// word-wide SRAM with ack handshake and timeout.
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        a_we;
    logic [2:0]  a_func3;
    logic [1:0]  a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata_rep;
    logic [31:0] a_rdata_ext;
    logic        a_misaligned;
    logic        a_illegal;

    // One aligner serves both phases: live request in IDLE, latched request afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            a_we    = req_we;
            a_func3 = req_func3;
            a_addr  = req_addr[1:0];
        end else begin
            a_we    = we_q;
            a_func3 = func3_q;
            a_addr  = addr_lo_q;
        end
    end

    lsu_align u_align (
        .we         (a_we),
        .func3      (a_func3),
        .addr       (a_addr),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_rep  (a_wdata_rep),
        .rdata_ext  (a_rdata_ext),
        .misaligned (a_misaligned),
        .illegal    (a_illegal)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        func3_d      = func3_q;
        addr_lo_d    = addr_lo_q;
        wait_cnt_d   = wait_cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    func3_d   = req_func3;
                    addr_lo_d = req_addr[1:0];
                    if (a_illegal || a_misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = BUS;
                        wait_cnt_d  = '0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = a_be;
                        mem_addr_d  = req_addr[ADDR_W-1:2];
                        mem_wdata_d = a_wdata_rep;
                    end
                end
            end
            BUS: begin
                // An ack in the final wait cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d      = RESP;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? '0 : a_rdata_ext;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d      = RESP;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            func3_q      <= '0;
            addr_lo_q    <= '0;
            wait_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            addr_lo_q    <= addr_lo_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed self-checking bench for lsu_mem_bridge (TIMEOUT=4).
module tb_lsu_mem_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    lsu_mem_bridge #(
        .ADDR_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns in cycle N+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load_ack(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, 32'(resp_err), 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_func3 = 3'b010;
        req_addr = 16'h0010;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;

        // Reset, with a request presented that must be dropped
        tick();
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        tick();
        chk("rst_drop_mem_en", 32'(mem_en), 32'd0);

        // LW at 0x0010, ack in first BUS cycle
        issue(1'b0, 3'b010, 16'h0010, 32'h0);
        chk("lw_mem_en", 32'(mem_en), 32'd1);
        chk("lw_mem_we", 32'(mem_we), 32'd0);
        chk("lw_mem_addr", 32'(mem_addr), 32'h0004);
        chk("lw_mem_be", 32'(mem_be), 32'hF);
        chk("lw_ready", 32'(req_ready), 32'd0);
        chk("lw_no_early_valid", 32'(resp_valid), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk("lw_valid", 32'(resp_valid), 32'd1);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(resp_err), 32'd0);
        chk("lw_mem_en_drop", 32'(mem_en), 32'd0);
        tick();
        chk("lw_valid_pulse", 32'(resp_valid), 32'd0);
        chk("lw_ready_back", 32'(req_ready), 32'd1);
        chk("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Sign / zero extension on 0x80FF7F01
        load_ack("lb3", 3'b000, 16'h0003, 32'h80FF7F01, 32'hFFFFFF80);
        load_ack("lbu3", 3'b100, 16'h0003, 32'h80FF7F01, 32'h00000080);
        load_ack("lh2", 3'b001, 16'h0002, 32'h80FF7F01, 32'hFFFF80FF);
        load_ack("lhu0", 3'b101, 16'h0000, 32'h80FF7F01, 32'h00007F01);
        load_ack("lb1", 3'b000, 16'h0001, 32'h80FF7F01, 32'h0000007F);

        // SB at 0x0005
        issue(1'b1, 3'b000, 16'h0005, 32'h12345678);
        chk("sb_mem_we", 32'(mem_we), 32'd1);
        chk("sb_mem_be", 32'(mem_be), 32'b0010);
        chk("sb_mem_wdata", mem_wdata, 32'h78787878);
        chk("sb_mem_addr", 32'(mem_addr), 32'h0001);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        chk("sb_valid", 32'(resp_valid), 32'd1);
        chk("sb_rdata", resp_rdata, 32'd0);
        chk("sb_err", 32'(resp_err), 32'd0);
        tick();

        // SH at 0x0006, ack after two wait cycles
        issue(1'b1, 3'b001, 16'h0006, 32'h12345678);
        chk("sh_mem_be", 32'(mem_be), 32'b1100);
        chk("sh_mem_wdata", mem_wdata, 32'h56785678);
        tick();
        chk("sh_stable_be", 32'(mem_be), 32'b1100);
        chk("sh_stable_en", 32'(mem_en), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sh_valid", 32'(resp_valid), 32'd1);
        chk("sh_rdata", resp_rdata, 32'd0);
        tick();

        // Misaligned LW at 0x0002
        issue(1'b0, 3'b010, 16'h0002, 32'h0);
        chk("mis_valid", 32'(resp_valid), 32'd1);
        chk("mis_err", 32'(resp_err), 32'd1);
        chk("mis_rdata", resp_rdata, 32'd0);
        chk("mis_mem_en", 32'(mem_en), 32'd0);
        tick();
        chk("mis_ready", 32'(req_ready), 32'd1);

        // Illegal load func3=011
        issue(1'b0, 3'b011, 16'h0000, 32'h0);
        chk("ill_ld_valid", 32'(resp_valid), 32'd1);
        chk("ill_ld_err", 32'(resp_err), 32'd1);
        chk("ill_ld_mem_en", 32'(mem_en), 32'd0);
        tick();

        // Illegal store func3=100 (unsigned is load-only)
        issue(1'b1, 3'b100, 16'h0000, 32'h0);
        chk("ill_st_valid", 32'(resp_valid), 32'd1);
        chk("ill_st_err", 32'(resp_err), 32'd1);
        chk("ill_st_mem_en", 32'(mem_en), 32'd0);
        tick();

        // Timeout: mem_en high exactly 4 cycles, then error response
        issue(1'b0, 3'b010, 16'h0020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_en_%0d", i), 32'(mem_en), 32'd1);
            chk($sformatf("to_novalid_%0d", i), 32'(resp_valid), 32'd0);
            tick();
        end
        chk("to_en_drop", 32'(mem_en), 32'd0);
        chk("to_valid", 32'(resp_valid), 32'd1);
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_rdata", resp_rdata, 32'd0);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("late_ack_valid2", 32'(resp_valid), 32'd0);
        chk("late_ack_ready", 32'(req_ready), 32'd1);

        // Ack in the last allowed wait cycle completes without error
        issue(1'b0, 3'b010, 16'h0024, 32'h0);
        tick();
        tick();
        tick();
        chk("edge_en", 32'(mem_en), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk("edge_valid", 32'(resp_valid), 32'd1);
        chk("edge_err", 32'(resp_err), 32'd0);
        chk("edge_rdata", resp_rdata, 32'hCAFEF00D);
        tick();

        // Reset while in BUS
        issue(1'b0, 3'b010, 16'h0030, 32'h0);
        chk("rb_in_bus", 32'(mem_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_mem_en", 32'(mem_en), 32'd0);
        chk("rb_ready", 32'(req_ready), 32'd1);
        chk("rb_valid", 32'(resp_valid), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rb_valid2", 32'(resp_valid), 32'd0);
        load_ack("rb_lw", 3'b010, 16'h0040, 32'hA5A55A5A, 32'hA5A55A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Load/store bridge between the multicycle core's memory-access stage and a word-wide data SRAM with an acknowledge handshake. It accepts one byte, halfword or word request at a time and generates byte enables and replicated write data. It sign- or zero-extends load data and returns a single-cycle response. Misaligned accesses, illegal func3 codes and bus timeouts are reported as errors.

## Interface
Parameters:
- ADDR_W, 16, byte-address width; the SRAM word address is ADDR_W-2 bits.
- TIMEOUT, 16, number of bus-wait cycles without mem_ack before an error response; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  bridge can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 access size and signedness.
- req_addr  in  ADDR_W  byte address (core ALUOut).
- req_wdata  in  32  store data (core B register).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal or timeout.
- mem_en  out  1  bus request, held until mem_ack or timeout.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid in the cycle mem_ack is high.
- mem_ack  in  1  SRAM completion; sampled only while mem_en=1.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, latch we, func3, addr and wdata.
  - A legal, aligned request goes to BUS.
  - Otherwise go to RESP with err=1.
- Legal codes. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - mem_be is driven for loads too.
- Store data replication: byte {4{wdata[7:0]}}, halfword {2{wdata[15:0]}}, word unchanged.
- BUS: mem_en=1 and mem_we=latched we; all mem_* outputs stay stable.
  - When mem_ack=1, capture mem_rdata, go to RESP.
  - When the wait counter reaches TIMEOUT without mem_ack, go to RESP with err=1.
- Load formatting:
  - Select the lane by addr[1:0] (byte) or addr[1] (halfword).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next response.
- Only one request is outstanding at a time. req_valid outside IDLE is ignored; there is no queuing.
- A mem_ack received outside BUS is ignored, including a late ack after a timeout.

## Timing
- Reset values: state IDLE, req_ready=1 from the first post-reset cycle, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wait counter 0.
- Requests presented in the reset cycle are dropped.
- Accept edge N:
  - mem_en is high in cycle N+1.
  - If mem_ack is high in cycle N+k (k≥1), resp_valid is high in cycle N+k+1.
  - Minimum accept-to-response latency is 2 cycles.
- Error before bus (misaligned or illegal): resp_valid in N+1, mem_en never asserted.
- Timeout: mem_en is high for exactly TIMEOUT cycles, then drops. resp_valid with err follows in the next cycle.
- Back-to-back: req_ready returns in the cycle after resp_valid, so the next accept is at N+k+2 at the earliest.
- Reset mid-operation, in any state: the edge with rst=1 forces IDLE and clears mem_en. The pending response is lost.
- All outputs are registered except req_ready, which is decoded from state.

## Structure
- Package lsu_mem_bridge_pkg:
  - state enum (IDLE, BUS, RESP)
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - access-size enum
- Sub-module lsu_align, combinational:
  - inputs func3, addr[1:0], wdata, rdata
  - outputs be, wdata_rep, rdata_ext, misaligned, illegal
- The top-level FSM, wait counter and registers are in lsu_mem_bridge.

## Test plan
- LW at 0x0010, mem_ack in the first BUS cycle with mem_rdata=0xDEADBEEF:
  - mem_addr=0x0004, mem_be=1111
  - resp_valid 2 cycles after accept with rdata=0xDEADBEEF, err=0
- Sign and zero extension with mem_rdata=0x80FF7F01:
  - LB at 0x0003 → 0xFFFFFF80
  - LBU at 0x0003 → 0x00000080
  - LH at 0x0002 → 0xFFFF80FF
  - LHU at 0x0000 → 0x00007F01
- Stores with wdata=0x12345678:
  - SB at 0x0005 → mem_be=0010, mem_wdata=0x78787878
  - SH at 0x0006 → mem_be=1100, mem_wdata=0x56785678
  - resp_rdata=0
- Error cases, mem_en never asserted:
  - LW at 0x0002 → resp_valid at N+1, err=1
  - func3=011 load → resp_valid at N+1, err=1
- TIMEOUT=4, mem_ack held low:
  - mem_en high exactly 4 cycles, then resp_valid with err=1
  - a later mem_ack pulse produces no response
- rst asserted while in BUS:
  - next cycle mem_en=0, req_ready=1, no resp_valid
  - a following LW completes normally
